// File: rtl/spongent_sponge_ctrl_pkg.sv
// Shared constants and state encoding for the Spongent sponge-mode controller.
package spongent_sponge_ctrl_pkg;

  localparam int          B_DEF       = 264;     // sponge state width
  localparam int          R_DEF       = 8;       // rate: one byte per block
  localparam int          HASH_DEF    = 256;     // digest length
  localparam int          IV_W_DEF    = 16;      // round-counter LFSR width
  localparam logic [15:0] IV_INIT_DEF = 16'h00c6;
  localparam int          OCNT_W      = 6;       // output block counter width

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABSORB,
    ST_PAD,
    ST_PERM,
    ST_GAP,
    ST_SQUEEZE
  } state_t;

endpackage

// File: rtl/spongent_sponge_ctrl_if.sv
// Bundle of the message stream, digest stream and Permute handshake seen by
// the sponge controller. The controller takes the slave side; the byte-stream
// front end together with Permute form the master side.
interface spongent_sponge_ctrl_if
  import spongent_sponge_ctrl_pkg::*;
#(
  parameter int B    = B_DEF,
  parameter int R    = R_DEF,
  parameter int IV_W = IV_W_DEF
);

  logic            start;
  logic            busy;
  logic [R-1:0]    msg_data;
  logic            msg_valid;
  logic            msg_last;
  logic            msg_ready;
  logic            perm_en;
  logic [B-1:0]    perm_state;
  logic [IV_W-1:0] perm_iv;
  logic [IV_W-1:0] perm_inv_iv;
  logic [B-1:0]    perm_result;
  logic            perm_rdy;
  logic [R-1:0]    hash_data;
  logic            hash_valid;
  logic            hash_last;
  logic            hash_ready;

  modport slave (
    input  start, msg_data, msg_valid, msg_last, perm_result, perm_rdy, hash_ready,
    output busy, msg_ready, perm_en, perm_state, perm_iv, perm_inv_iv,
           hash_data, hash_valid, hash_last
  );

  modport master (
    output start, msg_data, msg_valid, msg_last, perm_result, perm_rdy, hash_ready,
    input  busy, msg_ready, perm_en, perm_state, perm_iv, perm_inv_iv,
           hash_data, hash_valid, hash_last
  );

endinterface

// File: rtl/spongent_sponge_ctrl.sv
// Sponge-mode controller for the Spongent hash: owns the sponge state,
// absorbs message bytes with 10* padding, drives the Permute en/rdy
// handshake and squeezes the digest out one rate block at a time.
module spongent_sponge_ctrl
  import spongent_sponge_ctrl_pkg::*;
#(
  parameter int              B       = B_DEF,
  parameter int              R       = R_DEF,
  parameter int              HASH    = HASH_DEF,
  parameter int              IV_W    = IV_W_DEF,
  parameter logic [IV_W-1:0] IV_INIT = IV_W'(IV_INIT_DEF)
) (
  input  logic                   clk,
  input  logic                   rst,
  spongent_sponge_ctrl_if.slave  bus
);

  localparam int                NOUT      = HASH / R;
  localparam logic [OCNT_W-1:0] OCNT_LAST = OCNT_W'(NOUT - 1);
  // 10* padding of a full block: a single leading one in the top rate bit.
  localparam logic [R-1:0]      PAD_BLK   = {1'b1, {(R-1){1'b0}}};

  state_t            state;
  logic [B-1:0]      s;
  logic              last_f;
  logic              pad_f;
  logic [OCNT_W-1:0] ocnt;

  logic              busy_q;
  logic              msg_ready_q;
  logic              perm_en_q;
  logic              hash_valid_q;
  logic              hash_last_q;
  logic [R-1:0]      hash_data_q;

  // Sponge sequencer: state, sponge register, flags and registered outputs.
  // NOTE: non-blocking assignments throughout so every register samples the
  // values of the previous cycle regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the wide sponge state is cleared on reset too, so that
      // perm_state and the digest path never expose a previous message.
      state        <= ST_IDLE;
      s            <= '0;
      last_f       <= 1'b0;
      pad_f        <= 1'b0;
      ocnt         <= '0;
      busy_q       <= 1'b0;
      msg_ready_q  <= 1'b0;
      perm_en_q    <= 1'b0;
      hash_valid_q <= 1'b0;
      hash_last_q  <= 1'b0;
      hash_data_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            s           <= '0;
            last_f      <= 1'b0;
            pad_f       <= 1'b0;
            ocnt        <= '0;
            busy_q      <= 1'b1;
            msg_ready_q <= 1'b1;
            state       <= ST_ABSORB;
          end
        end

        ST_ABSORB: begin
          if (bus.msg_valid) begin
            s[R-1:0]    <= s[R-1:0] ^ bus.msg_data;
            last_f      <= bus.msg_last;
            msg_ready_q <= 1'b0;
            perm_en_q   <= 1'b1;
            state       <= ST_PERM;
          end
        end

        ST_PAD: begin
          s[R-1:0]  <= s[R-1:0] ^ PAD_BLK;
          pad_f     <= 1'b1;
          perm_en_q <= 1'b1;
          state     <= ST_PERM;
        end

        ST_PERM: begin
          // perm_state is the S register itself, so it stays put until rdy.
          if (bus.perm_rdy) begin
            s         <= bus.perm_result;
            perm_en_q <= 1'b0;
            state     <= ST_GAP;
          end
        end

        ST_GAP: begin
          // One cycle with en low so Permute sees a fresh rising edge.
          if (pad_f) begin
            hash_valid_q <= 1'b1;
            hash_data_q  <= s[R-1:0];
            hash_last_q  <= (ocnt == OCNT_LAST);
            state        <= ST_SQUEEZE;
          end else if (last_f) begin
            state <= ST_PAD;
          end else begin
            msg_ready_q <= 1'b1;
            state       <= ST_ABSORB;
          end
        end

        ST_SQUEEZE: begin
          if (bus.hash_ready) begin
            hash_valid_q <= 1'b0;
            hash_last_q  <= 1'b0;
            hash_data_q  <= '0;
            if (ocnt == OCNT_LAST) begin
              busy_q <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              ocnt      <= ocnt + OCNT_W'(1);
              perm_en_q <= 1'b1;
              state     <= ST_PERM;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.msg_ready   = msg_ready_q;
  assign bus.perm_en     = perm_en_q;
  assign bus.perm_state  = s;
  assign bus.perm_iv     = IV_INIT;
  assign bus.perm_inv_iv = '0;
  assign bus.hash_data   = hash_data_q;
  assign bus.hash_valid  = hash_valid_q;
  assign bus.hash_last   = hash_last_q;

endmodule

// File: tb/tb_spongent_sponge_ctrl.sv
// Self-checking bench for spongent_sponge_ctrl with a stub permutation
// (result = state + 1, rdy a few cycles after en rises). Expected digest
// bytes and permutation inputs are pushed to scoreboards from a byte-level
// sponge model and popped as the DUT produces them.
module tb_spongent_sponge_ctrl;
  import spongent_sponge_ctrl_pkg::*;

  localparam int          B       = B_DEF;
  localparam int          R       = R_DEF;
  localparam int          IV_W    = IV_W_DEF;
  localparam int          NOUT    = HASH_DEF / R_DEF;
  localparam logic [15:0] IV_INIT = IV_INIT_DEF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spongent_sponge_ctrl_if #(.B(B), .R(R), .IV_W(IV_W)) bus ();

  spongent_sponge_ctrl #(
    .B(B), .R(R), .HASH(HASH_DEF), .IV_W(IV_W), .IV_INIT(IV_INIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stub permutation: counts edges with en high, rdy after four of them.
  logic [2:0] stub_cnt = 3'd0;
  always @(posedge clk) begin
    if (!bus.perm_en)          stub_cnt <= 3'd0;
    else if (stub_cnt != 3'd7) stub_cnt <= stub_cnt + 3'd1;
  end
  assign bus.perm_result = bus.perm_state + B'(1);
  assign bus.perm_rdy    = bus.perm_en && (stub_cnt >= 3'd4);

  int checks   = 0;
  int failures = 0;

  logic [7:0] msg_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_perm_q[$];

  int         obs_outputs;
  int         obs_perm_pulses;
  int         obs_last_count;
  int         obs_last_idx;
  logic       obs_busy_after;
  logic       obs_start_busy;
  logic       obs_timeout;
  logic [7:0] obs_first_hash;
  int         obs_stall_cycles;
  int         obs_stall_changes;
  int         obs_stall_perm;
  logic       obs_poke_hv;

  task automatic idle_inputs();
    bus.start      = 1'b0;
    bus.msg_valid  = 1'b0;
    bus.msg_data   = '0;
    bus.msg_last   = 1'b0;
    bus.hash_ready = 1'b0;
  endtask

  // Byte-level sponge model over msg_q; only S[7:0] is visible and +1 never
  // carries into it from above, so an 8-bit model is exact.
  task automatic push_expected();
    logic [7:0] s = 8'h00;
    foreach (msg_q[i]) begin
      s = s ^ msg_q[i];
      exp_perm_q.push_back(s);
      s = s + 8'd1;
    end
    s = s ^ 8'h80;
    exp_perm_q.push_back(s);
    s = s + 8'd1;
    for (int i = 0; i < NOUT; i++) begin
      exp_q.push_back(s);
      if (i < NOUT - 1) begin
        exp_perm_q.push_back(s);
        s = s + 8'd1;
      end
    end
  endtask

  // Runs one hash of msg_q starting at a negedge with the DUT in IDLE.
  // Optional stall of stall_len cycles on block stall_blk; poke drives
  // msg_valid during PERM and a start pulse during SQUEEZE.
  task automatic run_hash(input string tag, input int stall_blk,
                          input int stall_len, input bit poke);
    int         mi = 0;
    int         blk = 0;
    int         budget = 0;
    int         stall_left = stall_len;
    bit         prev_en = 1'b0;
    bit         poked = 1'b0;
    bit         finishing = 1'b0;
    bit         done = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] e;
    obs_outputs = 0; obs_perm_pulses = 0; obs_last_count = 0; obs_last_idx = -1;
    obs_busy_after = 1'bx; obs_timeout = 1'b0; obs_first_hash = 8'hxx;
    obs_stall_cycles = 0; obs_stall_changes = 0; obs_stall_perm = 0;
    obs_poke_hv = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    obs_start_busy = bus.busy;
    while (!done && budget < 3000) begin
      budget++;
      bus.msg_valid  = 1'b0;
      bus.msg_last   = 1'b0;
      bus.hash_ready = 1'b0;
      bus.start      = 1'b0;
      if (poked && obs_poke_hv === 1'b0) obs_poke_hv = bus.hash_valid;
      if (bus.perm_en && !prev_en) begin
        obs_perm_pulses++;
        checks++;
        if (exp_perm_q.size() == 0) begin
          failures++;
          $display("FAIL %s perm_input: unexpected pulse got=%02h", tag, bus.perm_state[7:0]);
        end else begin
          e = exp_perm_q.pop_front();
          if (bus.perm_state[7:0] !== e) begin
            failures++;
            $display("FAIL %s perm_input #%0d: got=%02h exp=%02h", tag,
                     obs_perm_pulses, bus.perm_state[7:0], e);
          end
        end
      end
      prev_en = bus.perm_en;
      if (bus.msg_ready && mi < msg_q.size()) begin
        bus.msg_valid = 1'b1;
        bus.msg_data  = msg_q[mi];
        bus.msg_last  = (mi == msg_q.size() - 1);
        mi++;
      end else if (poke && bus.perm_en) begin
        bus.msg_valid = 1'b1;
        bus.msg_data  = 8'hff;
        bus.msg_last  = 1'b1;
      end
      if (bus.hash_valid) begin
        if (blk == stall_blk && stall_left > 0) begin
          if (stall_left == stall_len) held = bus.hash_data;
          else if (bus.hash_data !== held) obs_stall_changes++;
          if (bus.perm_en) obs_stall_perm++;
          stall_left--;
          obs_stall_cycles++;
        end else if (poke && blk == 2 && !poked) begin
          bus.start = 1'b1;
          poked = 1'b1;
        end else begin
          bus.hash_ready = 1'b1;
          if (blk == 0) obs_first_hash = bus.hash_data;
          obs_outputs++;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s digest: unexpected block %0d got=%02h", tag, blk, bus.hash_data);
          end else begin
            e = exp_q.pop_front();
            if (bus.hash_data !== e) begin
              failures++;
              $display("FAIL %s digest blk %0d: got=%02h exp=%02h", tag, blk, bus.hash_data, e);
            end
          end
          if (bus.hash_last) begin
            obs_last_count++;
            obs_last_idx = blk;
            finishing = 1'b1;
          end
          blk++;
        end
      end
      @(negedge clk);
      if (finishing) begin
        obs_busy_after = bus.busy;
        done = 1'b1;
      end
    end
    idle_inputs();
    if (!done) obs_timeout = 1'b1;
    checks++;
    if (exp_q.size() != 0 || exp_perm_q.size() != 0) begin
      failures++;
      $display("FAIL %s scoreboard: %0d digest and %0d perm entries left", tag,
               exp_q.size(), exp_perm_q.size());
    end
    exp_q.delete();
    exp_perm_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0)       begin failures++; $display("FAIL reset busy: got=%b exp=0", bus.busy); end
    checks++; if (bus.msg_ready !== 1'b0)  begin failures++; $display("FAIL reset msg_ready: got=%b exp=0", bus.msg_ready); end
    checks++; if (bus.perm_en !== 1'b0)    begin failures++; $display("FAIL reset perm_en: got=%b exp=0", bus.perm_en); end
    checks++; if (bus.hash_valid !== 1'b0) begin failures++; $display("FAIL reset hash_valid: got=%b exp=0", bus.hash_valid); end
    checks++; if (bus.hash_last !== 1'b0)  begin failures++; $display("FAIL reset hash_last: got=%b exp=0", bus.hash_last); end
    checks++; if (bus.hash_data !== 8'h00) begin failures++; $display("FAIL reset hash_data: got=%02h exp=00", bus.hash_data); end
    checks++; if (bus.perm_state !== '0)   begin failures++; $display("FAIL reset perm_state: nonzero got=%h", bus.perm_state); end
    checks++; if (bus.perm_iv !== IV_INIT) begin failures++; $display("FAIL reset perm_iv: got=%h exp=%h", bus.perm_iv, IV_INIT); end
    checks++; if (bus.perm_inv_iv !== '0)  begin failures++; $display("FAIL reset perm_inv_iv: got=%h exp=0", bus.perm_inv_iv); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    msg_q = {8'h00};
    push_expected();
    run_hash("single", -1, 0, 1'b0);
    checks++; if (obs_timeout !== 1'b0)    begin failures++; $display("FAIL single timeout: run did not finish"); end
    checks++; if (obs_perm_pulses != 33)   begin failures++; $display("FAIL single perm_pulses: got=%0d exp=33", obs_perm_pulses); end
    checks++; if (obs_outputs != NOUT)     begin failures++; $display("FAIL single outputs: got=%0d exp=%0d", obs_outputs, NOUT); end
    checks++; if (obs_first_hash !== 8'h82) begin failures++; $display("FAIL single first_hash: got=%02h exp=82", obs_first_hash); end
    checks++; if (obs_last_count != 1 || obs_last_idx != NOUT - 1) begin
      failures++; $display("FAIL single hash_last: count=%0d idx=%0d exp count=1 idx=%0d",
                           obs_last_count, obs_last_idx, NOUT - 1);
    end
    checks++; if (obs_busy_after !== 1'b0) begin failures++; $display("FAIL single busy_after: got=%b exp=0", obs_busy_after); end
  endtask

  task automatic test_two_bytes();
    msg_q = {8'h10, 8'h20};
    push_expected();
    run_hash("two_bytes", -1, 0, 1'b0);
    checks++; if (obs_timeout !== 1'b0)     begin failures++; $display("FAIL two_bytes timeout: run did not finish"); end
    checks++; if (obs_perm_pulses != 34)    begin failures++; $display("FAIL two_bytes perm_pulses: got=%0d exp=34", obs_perm_pulses); end
    checks++; if (obs_first_hash !== 8'hb3) begin failures++; $display("FAIL two_bytes first_hash: got=%02h exp=b3", obs_first_hash); end
  endtask

  task automatic test_back_to_back();
    msg_q = {8'($urandom), 8'($urandom), 8'($urandom)};
    push_expected();
    run_hash("b2b_first", -1, 0, 1'b0);
    checks++; if (obs_busy_after !== 1'b0) begin failures++; $display("FAIL b2b_first busy_after: got=%b exp=0", obs_busy_after); end
    msg_q = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    push_expected();
    run_hash("b2b_second", -1, 0, 1'b0);
    checks++; if (obs_start_busy !== 1'b1) begin failures++; $display("FAIL b2b start_busy: got=%b exp=1", obs_start_busy); end
    checks++; if (obs_perm_pulses != 37)   begin failures++; $display("FAIL b2b perm_pulses: got=%0d exp=37", obs_perm_pulses); end
    checks++; if (obs_timeout !== 1'b0)    begin failures++; $display("FAIL b2b timeout: run did not finish"); end
  endtask

  task automatic test_backpressure();
    msg_q = {8'h5a};
    push_expected();
    run_hash("backpressure", 5, 10, 1'b0);
    checks++; if (obs_stall_cycles != 10) begin failures++; $display("FAIL bp stall_cycles: got=%0d exp=10", obs_stall_cycles); end
    checks++; if (obs_stall_changes != 0) begin failures++; $display("FAIL bp data_stable: changes=%0d exp=0", obs_stall_changes); end
    checks++; if (obs_stall_perm != 0)    begin failures++; $display("FAIL bp perm_en_in_stall: got=%0d exp=0", obs_stall_perm); end
    checks++; if (obs_last_idx != NOUT - 1) begin failures++; $display("FAIL bp last_idx: got=%0d exp=%0d", obs_last_idx, NOUT - 1); end
  endtask

  task automatic test_reset_mid_perm();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.msg_valid = 1'b1;
    bus.msg_data  = 8'h00;
    bus.msg_last  = 1'b1;
    @(negedge clk);
    idle_inputs();
    checks++; if (bus.perm_en !== 1'b1) begin failures++; $display("FAIL rst_mid perm_en_before: got=%b exp=1", bus.perm_en); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.perm_en !== 1'b0)  begin failures++; $display("FAIL rst_mid perm_en: got=%b exp=0", bus.perm_en); end
    checks++; if (bus.busy !== 1'b0)     begin failures++; $display("FAIL rst_mid busy: got=%b exp=0", bus.busy); end
    checks++; if (bus.perm_state !== '0) begin failures++; $display("FAIL rst_mid perm_state: nonzero got=%h", bus.perm_state); end
    rst = 1'b1;
    msg_q = {8'h00};
    push_expected();
    run_hash("after_reset", -1, 0, 1'b0);
    checks++; if (obs_perm_pulses != 33)   begin failures++; $display("FAIL after_reset perm_pulses: got=%0d exp=33", obs_perm_pulses); end
    checks++; if (obs_first_hash !== 8'h82) begin failures++; $display("FAIL after_reset first_hash: got=%02h exp=82", obs_first_hash); end
    checks++; if (obs_busy_after !== 1'b0) begin failures++; $display("FAIL after_reset busy_after: got=%b exp=0", obs_busy_after); end
  endtask

  task automatic test_ignored_inputs();
    msg_q = {8'h3c, 8'hc3};
    push_expected();
    run_hash("ignored", -1, 0, 1'b1);
    checks++; if (obs_poke_hv !== 1'b1)     begin failures++; $display("FAIL ignored hash_valid_after_start: got=%b exp=1", obs_poke_hv); end
    checks++; if (obs_perm_pulses != 34)    begin failures++; $display("FAIL ignored perm_pulses: got=%0d exp=34", obs_perm_pulses); end
    checks++; if (obs_timeout !== 1'b0)     begin failures++; $display("FAIL ignored timeout: run did not finish"); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_two_bytes();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_perm();
    test_ignored_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spongent_sponge_ctrl.md
# spongent_sponge_ctrl

Sponge-mode controller for the Spongent hash core. It owns the b-bit sponge state, absorbs message bytes into the rate, and applies 10* padding. It sequences the `Permute` datapath through its `en`/`rdy` handshake, then squeezes the digest out one rate block at a time. It sits between the byte-stream front end and `Permute` and is the only block that drives `Permute`.

## Interface
Parameters:
- `B`, 264: state width (bits), equals `Permute` state width.
- `R`, 8: rate (bits); one message/digest byte per block.
- `HASH`, 256: digest length (bits); `NOUT = HASH/R` = 32 output blocks.
- `IV_W`, 16: round-counter LFSR width.
- `IV_INIT`, 16'hc6: value driven on `perm_iv` for every permutation.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `start` in 1: begin a new hash; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `msg_data` in R: message block.
- `msg_valid` in 1: `msg_data` valid.
- `msg_last` in 1: marks final message block; qualified by `msg_valid`.
- `msg_ready` out 1: high only in ABSORB.
- `perm_en` out 1: to `Permute.en`.
- `perm_state` out B: to `Permute.state_in`.
- `perm_iv` out IV_W: to `Permute.IV_in`; constant `IV_INIT`.
- `perm_inv_iv` out IV_W: to `Permute.INV_IV_in`; constant 0.
- `perm_result` in B: from `Permute.state_out`.
- `perm_rdy` in 1: from `Permute.rdy`.
- `hash_data` out R: digest block; equals `S[R-1:0]` in SQUEEZE, else 0.
- `hash_valid` out 1: high only in SQUEEZE.
- `hash_last` out 1: high with `hash_valid` on block `NOUT-1`.

## Operation
- Registers:
  - S (B bits): sponge state.
  - last_f: last message block absorbed.
  - pad_f: padding block absorbed.
  - ocnt (6 bits): output block count.
- IDLE: `start`=1 gives S←0, last_f←0, pad_f←0, ocnt←0, then go to ABSORB.
- ABSORB: `msg_ready`=1. When `msg_valid`: S[R-1:0] ^= `msg_data`, last_f ← `msg_last`, then go to PERM.
- PAD: one cycle. S[R-1:0] ^= 8'h80, pad_f←1, then go to PERM.
- PERM: `perm_en`=1; `perm_state`=S is held stable throughout. When `perm_rdy`=1: S ← `perm_result`, then go to GAP.
- GAP: one cycle with `perm_en`=0, which guarantees an `en` low period between permutations. Next state:
  - pad_f=1 → SQUEEZE.
  - else last_f=1 → PAD.
  - else → ABSORB.
- SQUEEZE: `hash_valid`=1. When `hash_ready`=1:
  - ocnt = NOUT-1 → IDLE.
  - else ocnt++, then → PERM.
- Messages are at least 1 block; an empty message is not supported.
- Padding is always one extra block: 0x80.
- `start` outside IDLE is ignored.
- `msg_valid` outside ABSORB is ignored; the data is not consumed.
- Reset (`rst`=0 at a clock edge) in any state, including mid-permutation:
  - next state IDLE.
  - S, flags and ocnt cleared.
  - All outputs 0, except `perm_iv`=`IV_INIT`.
  - `Permute` is abandoned. Its next `en` rise restarts it.

## Timing
- Message block accepted at edge t → `perm_en`=1 from t+1 until the edge where `perm_rdy` is sampled 1 (edge t+P). S is updated at that edge.
- `perm_en`=0 for exactly one cycle (GAP) after each permutation.
- The next `msg_ready` or `hash_valid` is high at cycle t+P+1, or t+P+2 via PAD.
- Permutations per hash: (message blocks) + 1 (padding) + (NOUT−1) = blocks + 32.
- `hash_valid` stays asserted, with `hash_data` stable, until `hash_ready`; backpressure has no cycle limit.
- `busy` falls on the edge after the last handshake. `start` is honoured from that cycle on.

## Structure
- Shared package/header (`constants.vh`): B, R, HASH, IV_W, IV_INIT, state encodings (IDLE, ABSORB, PAD, PERM, GAP, SQUEEZE).
- Single module, no sub-modules.
- Top level instantiates `spongent_sponge_ctrl` alongside `Permute`.

## Test plan
All scenarios use a stub permutation: `perm_result` = `perm_state` + 1 (B-bit), with `perm_rdy` asserted 4 cycles after `perm_en` rises.
- **Reset:** hold `rst`=0 for 3 cycles → `busy`, `msg_ready`, `perm_en`, `hash_valid`, `hash_last` = 0; `hash_data`=0.
- **Single byte 0x00, `hash_ready`=1:** 33 `perm_en` pulses, 32 outputs 0x82, 0x83 … 0xA1; `hash_last` only on 0xA1; `busy` falls the next cycle.
- **Two bytes 0x10, 0x20:**
  - first permutation sees S[7:0]=0x10.
  - second permutation sees S[7:0]=0x11^0x20=0x31.
  - pad permutation sees 0x32^0x80=0xB2.
  - first digest byte is 0xB3.
- **Backpressure:** `hash_ready`=0 for 10 cycles on block 5 → `hash_data` stable, no `perm_en`, ocnt unchanged.
- **Reset mid-PERM:** assert `rst`=0 during the 2nd cycle of `perm_en` → next cycle IDLE, `perm_en`=0; a fresh hash then matches the single-byte scenario exactly.
- **Ignored inputs:** `start` pulsed in SQUEEZE, and `msg_valid` held in PERM → no state change, digest unaltered.
